// File: rtl/codeword_receiver.sv
// Receive side of the serial systematic link: forwards message bits, re-encodes them
// with the block-circulant generator and checks the regenerated parity against the stream.
module codeword_receiver #(
   parameter int K        = 1024,
   parameter int K_N      = 256,
   parameter int BLK_BITS = 2,
   parameter int CNT_BITS = 11,
   parameter int ERR_BITS = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                y,
   input  logic                y_valid,
   input  logic                sof,
   input  logic [K_N-1:0]      gen_seed,
   output logic [BLK_BITS-1:0] blk_sel,
   output logic                msg_out,
   output logic                msg_valid,
   output logic                done,
   output logic                parity_ok,
   output logic [ERR_BITS-1:0] err_cnt
);
   localparam int LG = $clog2(K_N);

   typedef enum logic [1:0] {IDLE, MSG, PAR, DONE} state_t;
   state_t state, state_nxt;

   logic [CNT_BITS-1:0] cnt, cnt_p1;
   logic [K_N-1:0]      acc, row, row_eff, acc_msg;
   logic [ERR_BITS-1:0] err_int, err_nxt;
   logic [LG-1:0]       pidx;
   logic                pend, pend_y;
   logic                start, in_msg, in_par, last_msg, last_par, mis;

   function automatic logic [K_N-1:0] rotr(input logic [K_N-1:0] x);
      return {x[0], x[K_N-1:1]};
   endfunction

   assign start    = y_valid & sof;
   assign in_msg   = y_valid & ~sof & (state == MSG);
   assign in_par   = y_valid & ~sof & (state == PAR);
   assign last_msg = in_msg & (cnt == CNT_BITS'(K-1));
   assign last_par = in_par & (cnt == CNT_BITS'(K+K_N-1));
   assign cnt_p1   = cnt + 1'b1;
   // K is a multiple of K_N, so the low bits of cnt give the parity index
   assign pidx     = ~cnt[LG-1:0];
   assign mis      = y ^ acc[pidx];
   assign err_nxt  = (mis && err_int != ERR_BITS'(K_N)) ? err_int + 1'b1 : err_int;

   // An abort mid-message sees the stale block's seed on bit 0; that bit is
   // deferred (pend) and folded in on bit 1, once blk_sel is back at block 0.
   always_comb begin
      row_eff = row;
      if (pend)
         row_eff = rotr(gen_seed);
      else if (cnt[LG-1:0] == '0)
         row_eff = gen_seed;
      acc_msg = acc ^ (y ? row_eff : '0) ^ ((pend & pend_y) ? gen_seed : '0);
   end

   always_comb begin
      state_nxt = state;
      if (start)
         state_nxt = MSG;
      else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            MSG:     if (last_msg) state_nxt = PAR;
            PAR:     if (last_par) state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         acc       <= '0;
         row       <= '0;
         err_int   <= '0;
         pend      <= 1'b0;
         pend_y    <= 1'b0;
         blk_sel   <= '0;
         msg_out   <= 1'b0;
         msg_valid <= 1'b0;
         done      <= 1'b0;
         parity_ok <= 1'b0;
         err_cnt   <= '0;
      end else begin
         done      <= 1'b0;
         msg_valid <= 1'b0;
         if (start) begin
            cnt       <= CNT_BITS'(1);
            err_int   <= '0;
            msg_out   <= y;
            msg_valid <= 1'b1;
            blk_sel   <= '0;
            if (blk_sel != '0) begin
               acc    <= '0;
               pend   <= 1'b1;
               pend_y <= y;
            end else begin
               acc    <= y ? gen_seed : '0;
               row    <= rotr(gen_seed);
               pend   <= 1'b0;
            end
         end else if (in_msg) begin
            acc       <= acc_msg;
            row       <= rotr(row_eff);
            pend      <= 1'b0;
            msg_out   <= y;
            msg_valid <= 1'b1;
            cnt       <= cnt_p1;
            blk_sel   <= last_msg ? '0 : BLK_BITS'(cnt_p1 >> LG);
         end else if (in_par) begin
            if (last_par) begin
               done      <= 1'b1;
               err_cnt   <= err_nxt;
               parity_ok <= (err_nxt == '0);
               cnt       <= '0;
               acc       <= '0;
               err_int   <= '0;
            end else begin
               cnt     <= cnt_p1;
               err_int <= err_nxt;
            end
         end
      end
   end
endmodule

// File: doc/codeword_receiver.md
Name: codeword_receiver

Overview:
- Receive end of the serial systematic encoder link: consumes the transmitted code stream y (K message bits, then K_N parity bits, MSB first).
- Forwards the message bits downstream and re-encodes them with the same block-circulant generator used by the encoder.
- Compares the regenerated parity bit-by-bit against the received parity, and reports pass/fail plus a mismatch count per frame.
- Generator first-row seeds come from the existing function-generator LUTs, selected by blk_sel.

Parameters:
- K, 1024, message length in bits.
- K_N, 256, parity length and circulant size; K must be a multiple of K_N.
- BLK_BITS, 2, width of blk_sel, log2(K/K_N).
- CNT_BITS, 11, width of bit counter; must hold K+K_N-1.
- ERR_BITS, 9, width of err_cnt, log2(K_N)+1.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- y  input  1  serial code bit.
- y_valid  input  1  y is consumed on a cycle only when high; low means stall.
- sof  input  1  start of frame, sampled with y_valid; that cycle's y is message bit 0.
- gen_seed  input  K_N  first row of the circulant for the current block; combinational from blk_sel.
- blk_sel  output  BLK_BITS  index of the current message block, registered.
- msg_out  output  1  forwarded message bit.
- msg_valid  output  1  msg_out valid, one pulse per message bit.
- done  output  1  one-cycle pulse at end of frame.
- parity_ok  output  1  frame result, held until next done.
- err_cnt  output  ERR_BITS  number of parity mismatches in the last frame, held until next done.

Behaviour:
- Reset (rst=0, async): state=IDLE; cnt, acc, row, blk_sel, msg_out, msg_valid, done, err_cnt all 0; parity_ok=0. Outputs are registered.
- States:
  - IDLE: wait for sof&y_valid, then go to MSG; that bit is processed as message bit 0.
  - MSG: handles cnt 0..K-1.
  - PAR: handles cnt K..K+K_N-1.
  - DONE: lasts exactly one cycle, then goes to IDLE.
- Any consumed cycle is a cycle with y_valid=1. All counters and accumulators advance only on consumed cycles.
- MSG, per consumed bit:
  - bidx = cnt mod K_N.
  - row_eff = gen_seed when bidx==0, else row.
  - If y=1, acc <= acc ^ row_eff.
  - row <= {row_eff[0], row_eff[K_N-1:1]} (rotate right by 1).
  - msg_out <= y and msg_valid <= 1, so latency is 1 cycle. msg_valid=0 on all other cycles.
  - blk_sel = cnt[CNT_BITS-1:log2 K_N] over 0..K-1, registered. It updates on the edge after the block's last bit, so gen_seed is stable by the next block's first bit.
- MSG to PAR transition: when cnt==K-1 is consumed.
- PAR, per consumed bit at parity index i = cnt-K:
  - Compare y with acc[K_N-1-i].
  - On mismatch, increment the internal error counter.
  - acc is not modified.
- PAR to DONE transition: when cnt==K+K_N-1 is consumed. On the DONE edge:
  - done=1.
  - err_cnt and parity_ok (= internal counter==0) are loaded.
  - cnt, acc and the internal counter are cleared.
- Boundaries and simultaneous events:
  - sof&y_valid in MSG or PAR aborts the frame without a done pulse. acc and counters restart, and that bit is treated as message bit 0. sof has priority over all other transitions.
  - sof during DONE is accepted as a new frame: done still pulses and the new bit 0 is processed in the same cycle.
  - sof without y_valid is ignored.
  - y_valid=0 in any state freezes everything except the done/msg_valid pulses, which self-clear.
  - Async reset mid-frame discards the frame; no done pulse.
  - err_cnt saturates at K_N, which is unreachable beyond K_N.

Test Plan:
- (K=16, K_N=4, seeds 4'b1000, 0100, 0010, 0001) All-zero message plus parity 0000 -> msg_valid 16 pulses of 0; done 1 cycle after the 20th bit; parity_ok=1; err_cnt=0.
- Only message bit 0 =1, parity 1000 -> parity_ok=1. Same message with parity 1001 -> parity_ok=0, err_cnt=1.
- Only message bit 2 =1 (block 0, seed 1000) -> expected parity 0010 accepted; blk_sel reads 0,0,0,0,1,1,1,1,2,… per consumed bit.
- Random 1024-bit message framed by the existing encoder chain -> parity_ok=1. Flip 3 parity bits -> err_cnt=3. Flip a message bit -> parity_ok=0.
- y_valid deasserted randomly on ~30% of cycles -> same results as the no-stall run; msg_valid pulses only on consumed message cycles.
- sof reasserted at bit 9 of a frame -> no done for the aborted frame; the following full frame reports the correct result. rst pulsed low mid-PAR -> all outputs 0 immediately.
